// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub accumulator controller and its command FIFO.
package addsub_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int DATA_W             = 8;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // One buffered command: opcode in the top two bits, operand below.
    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // ADD and SUB are the only ops that go through the external add/sub.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command buffer: DEPTH-entry FIFO of cmd_t with full/empty flags.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module cmd_fifo
    import addsub_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty/count gate every read, so contents never matter while empty.
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller: buffers commands, drives an external 8-bit add/sub,
// and returns the running accumulator with per-result and sticky overflow.
module addsub_acc_ctrl
    import addsub_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_data,
    output logic [7:0] as_a,
    output logic [7:0] as_b,
    output logic       as_opcode,
    input  logic [7:0] as_sum,
    input  logic       as_ovf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_acc,
    output logic       out_ovf,
    output logic       sticky_ovf,
    input  logic       clr_sticky
);

    state_e     state;
    state_e     state_nxt;
    cmd_t       fifo_wr;
    cmd_t       fifo_rd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    op_e        cur_op;
    logic [7:0] acc;
    logic       in_exec;

    assign fifo_wr  = cmd_t'{op: in_op, data: in_data};
    assign in_ready = !fifo_full;
    assign in_exec  = (state == EXEC);
    assign out_acc  = acc;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, FIFO pop and result-valid decode.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        state_nxt = state;
        fifo_pop  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on IDLE->EXEC; held otherwise so the add/sub result stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_a      <= '0;
            as_b      <= '0;
            as_opcode <= 1'b0;
            cur_op    <= OP_ADD;
        end else if (fifo_pop) begin
            as_a      <= acc;
            as_b      <= fifo_rd.data;
            as_opcode <= fifo_rd.op[0];
            cur_op    <= op_e'(fifo_rd.op);
        end
    end

    // Accumulator and per-result overflow, updated once per command in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            out_ovf <= 1'b0;
        end else if (in_exec) begin
            case (cur_op)
                OP_ADD, OP_SUB: begin
                    acc     <= as_sum;
                    out_ovf <= as_ovf;
                end
                OP_LOAD: begin
                    acc     <= as_b;
                    out_ovf <= 1'b0;
                end
                default: begin
                    acc     <= '0;
                    out_ovf <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: an overflowing ADD/SUB takes priority over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 sticky_ovf <= 1'b0;
        else if (in_exec && is_arith(cur_op) && as_ovf) sticky_ovf <= 1'b1;
        else if (clr_sticky)                        sticky_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Self-checking bench for addsub_acc_ctrl: directed vectors plus a
// command-level reference model checked every cycle.
module tb_addsub_acc_ctrl;
    import addsub_pkg::*;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_opcode;
    logic [7:0] as_sum;
    logic       as_ovf;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_acc;
    logic       out_ovf;
    logic       sticky_ovf;
    logic       clr_sticky = 1'b0;

    int         n_cmp = 0;
    int         n_fail = 0;

    logic [7:0] m_acc = 8'h00;
    res_t       exp_q[$];
    logic       hold_v = 1'b0;
    logic [7:0] hold_acc = 8'h00;
    logic       hold_ovf = 1'b0;

    addsub_acc_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .as_a       (as_a),
        .as_b       (as_b),
        .as_opcode  (as_opcode),
        .as_sum     (as_sum),
        .as_ovf     (as_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    // Downstream 8-bit add/sub with signed overflow from operand/result signs.
    always_comb begin
        if (as_opcode) begin
            as_sum = as_a - as_b;
            as_ovf = (as_a[7] != as_b[7]) && (as_sum[7] != as_a[7]);
        end else begin
            as_sum = as_a + as_b;
            as_ovf = (as_a[7] == as_b[7]) && (as_sum[7] != as_a[7]);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted command's result computed with signed integer arithmetic.
    task automatic model_accept(input logic [1:0] op, input logic [7:0] d);
        int   s;
        res_t r;
        case (op)
            OP_ADD: begin
                s     = int'($signed(m_acc)) + int'($signed(d));
                r.ovf = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                s     = int'($signed(m_acc)) - int'($signed(d));
                r.ovf = (s > 127) || (s < -128);
            end
            OP_LOAD: begin
                s     = int'(d);
                r.ovf = 1'b0;
            end
            default: begin
                s     = 0;
                r.ovf = 1'b0;
            end
        endcase
        m_acc = s[7:0];
        r.acc = m_acc;
        exp_q.push_back(r);
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    task automatic monitor_step();
        if (!rst_n) begin
            exp_q.delete();
            m_acc  = 8'h00;
            hold_v = 1'b0;
            return;
        end
        if (hold_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_acc", out_acc, hold_acc);
            check("hold_ovf", out_ovf, hold_ovf);
        end
        if (exp_q.size() == 0) begin
            check("no_stale_result", out_valid, 0);
        end else if (out_valid) begin
            check("result_acc", out_acc, exp_q[0].acc);
            check("result_ovf", out_ovf, exp_q[0].ovf);
            if (out_ready) void'(exp_q.pop_front());
        end
        hold_v   = out_valid && !out_ready;
        hold_acc = out_acc;
        hold_ovf = out_ovf;
        if (in_valid && in_ready) model_accept(in_op, in_data);
    endtask

    // Advance one clock: check at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        check("send_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [7:0] ea, input logic eo);
        int t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        check({name, "_valid"}, out_valid, 1);
        if (out_valid) begin
            check({name, "_acc"}, out_acc, ea);
            check({name, "_ovf"}, out_ovf, eo);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int t;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", sticky_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_as_a", as_a, 0);
        check("rst_as_b", as_b, 0);
        check("rst_as_opcode", as_opcode, 0);

        // Latency: LOAD 0x05 into idle block, result 3 edges after acceptance
        out_ready = 1'b1;
        send(OP_LOAD, 8'h05);
        check("lat_edge1_valid", out_valid, 0);
        tick();
        check("lat_edge2_valid", out_valid, 0);
        tick();
        check("lat_edge3_valid", out_valid, 1);
        check("lat_edge3_acc", out_acc, 8'h05);
        tick();

        // LOAD 0x64, ADD 0x32 -> 0x96 with overflow
        send(OP_LOAD, 8'h64);
        send(OP_ADD, 8'h32);
        wait_result("load64", 8'h64, 1'b0);
        wait_result("add32", 8'h96, 1'b1);
        check("add32_sticky", sticky_ovf, 1);
        check("add32_as_opcode", as_opcode, 0);
        check("add32_as_b", as_b, 8'h32);

        // LOAD 0x80, SUB 0x01 -> 0x7F overflow; CLEAR -> 0, sticky kept
        send(OP_LOAD, 8'h80);
        send(OP_SUB, 8'h01);
        send(OP_CLEAR, 8'h00);
        wait_result("load80", 8'h80, 1'b0);
        wait_result("sub01", 8'h7F, 1'b1);
        wait_result("clear", 8'h00, 1'b0);
        check("clear_sticky_kept", sticky_ovf, 1);
        check("clear_as_opcode", as_opcode, 1);

        // Clear sticky alone
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_only_sticky", sticky_ovf, 0);

        // Overflowing ADD in EXEC with clr_sticky in the same cycle: set wins
        send(OP_LOAD, 8'h7F);
        wait_result("load7f", 8'h7F, 1'b0);
        send(OP_ADD, 8'h01);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("set_wins_sticky", sticky_ovf, 1);
        check("set_wins_valid", out_valid, 1);
        check("set_wins_acc", out_acc, 8'h80);
        check("set_wins_ovf", out_ovf, 1);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_after_sticky", sticky_ovf, 0);

        // Back-pressure: 6 commands with out_ready low, only 5 accepted
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_op    = OP_ADD;
            in_data  = 8'(i + 1);
            if (i == 5) check("full_in_ready", in_ready, 0);
            if (in_ready) n_acc++;
            tick();
        end
        check("accepted_count", n_acc, 5);
        check("stall_valid", out_valid, 1);
        check("stall_first_acc", out_acc, 8'h81);
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        send(OP_ADD, 8'h06);
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            tick();
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_final_acc", out_acc, 8'h95);

        // Reset in RESP with 3 commands queued
        out_ready = 1'b0;
        send(OP_LOAD, 8'h11);
        send(OP_ADD, 8'h01);
        send(OP_ADD, 8'h02);
        send(OP_ADD, 8'h03);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_acc", out_acc, 8'h11);
        check("pre_rst_in_ready", in_ready, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_acc", out_acc, 0);
        check("async_rst_ovf", out_ovf, 0);
        check("async_rst_as_a", as_a, 0);
        check("async_rst_as_b", as_b, 0);
        check("async_rst_sticky", sticky_ovf, 0);
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_no_valid", out_valid, 0);
        send(OP_LOAD, 8'h22);
        wait_result("post_rst_load", 8'h22, 1'b0);

        check("end_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
